i2c_slave_burst: RTL

//  Parametrised I2C slave bridging an external I2C master to the on-chip register/memory bus.

---
 rtl/i2c_slave_burst.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_burst.sv
// i2c_slave_burst: I2C slave that bridges an external master onto the on-chip
// register/memory bus. SCL and SDA are oversampled on clk; burst writes and
// burst reads auto-increment a memory pointer that survives between transfers.
module i2c_slave_burst #(
   parameter int                      NUM_PIN_BITS = 3,
   parameter logic [6-NUM_PIN_BITS:0] DEV_ADDR_HI  = 4'b1010,
   parameter int                      MEM_ADDR_W   = 11,
   parameter int                      FILT_DEPTH   = 3,
   parameter int                      RD_LAT       = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_PIN_BITS-1:0] i2c_addr_bits,
   input  logic                    i2c_scl,
   input  logic                    i2c_sda_in,
   output logic                    i2c_sda_out,
   output logic                    i2c_op,
   output logic                    i2c_xfc_write,
   output logic [MEM_ADDR_W-1:0]   i2c_wraddr,
   output logic [7:0]              i2c_wdata,
   output logic                    i2c_rd_req,
   output logic [MEM_ADDR_W-1:0]   i2c_rdaddr,
   input  logic [7:0]              i2c_rdata
);

   localparam bit         TWO_BYTE  = (MEM_ADDR_W > 8);
   localparam logic [2:0] FILT_LAST = 3'(FILT_DEPTH - 1);

   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, ACK_DEV, MADDR_HI, ACK_MHI, MADDR_LO, ACK_MLO,
      WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_BUS
   } state_t;

   // Input path: index 0 is SCL, index 1 is SDA
   logic [1:0]      syncA_q, syncB_q, filt_q, filt_d, filtPrev_q;
   logic [1:0][2:0] cnt_q, cnt_d;

   logic sclF, sdaF, sclRise, sclFall, startCond, stopCond;

   state_t state_q, state_d;

   logic [2:0]            bitCnt_q, bitCnt_d;
   logic [7:0]            rxShift_q, rxShift_d, rxNext;
   logic [7:0]            txShift_q, txShift_d;
   logic [7:0]            hiByte_q, hiByte_d;
   logic                  rw_q, rw_d;
   logic [MEM_ADDR_W-1:0] ptr_q, ptr_d, ptrInc, ptrLoad;
   logic [15:0]           addrFull;
   logic [RD_LAT-1:0]     rdPipe_q, rdPipe_d;
   logic                  addrMatch;

   logic                  sda_q, sda_d, op_q, op_d;
   logic                  wrStb_q, wrStb_d, rdReq_q, rdReq_d;
   logic [MEM_ADDR_W-1:0] wrAddr_q, wrAddr_d, rdAddr_q, rdAddr_d;
   logic [7:0]            wrData_q, wrData_d;

   // A level is accepted only after it has differed from the filtered value for FILT_DEPTH clks
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         filt_d[i] = filt_q[i];
         cnt_d[i]  = 3'd0;
         if (syncB_q[i] != filt_q[i]) begin
            if (cnt_q[i] == FILT_LAST) begin
               filt_d[i] = syncB_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 3'd1;
            end
         end
      end
   end

   // Two-stage synchroniser and filter registers; the bus idles high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         syncA_q    <= 2'b11;
         syncB_q    <= 2'b11;
         filt_q     <= 2'b11;
         filtPrev_q <= 2'b11;
         cnt_q      <= '0;
      end else begin
         syncA_q    <= {i2c_sda_in, i2c_scl};
         syncB_q    <= syncA_q;
         filt_q     <= filt_d;
         filtPrev_q <= filt_q;
         cnt_q      <= cnt_d;
      end
   end

   assign sclF      = filt_q[0];
   assign sdaF      = filt_q[1];
   assign sclRise   = filt_q[0] & ~filtPrev_q[0];
   assign sclFall   = ~filt_q[0] & filtPrev_q[0];
   assign startCond = sclF & filtPrev_q[0] & ~filt_q[1] & filtPrev_q[1];
   assign stopCond  = sclF & filtPrev_q[0] & filt_q[1] & ~filtPrev_q[1];

   assign rxNext    = {rxShift_q[6:0], sdaF};
   assign addrMatch = (rxNext[7:1] == {DEV_ADDR_HI, i2c_addr_bits});
   assign addrFull  = TWO_BYTE ? {hiByte_q, rxNext} : {8'h00, rxNext};
   assign ptrLoad   = MEM_ADDR_W'(addrFull);
   assign ptrInc    = ptr_q + MEM_ADDR_W'(1);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: START/STOP override everything, otherwise advance on SCL rise
   always_comb begin
      state_d = state_q;
      if (startCond) begin
         state_d = DEV_ADDR;
      end else if (stopCond) begin
         state_d = IDLE;
      end else if (sclRise) begin
         case (state_q)
            DEV_ADDR: if (bitCnt_q == 3'd7) state_d = addrMatch ? ACK_DEV : IDLE;
            ACK_DEV:  state_d = rw_q ? RD_DATA : (TWO_BYTE ? MADDR_HI : MADDR_LO);
            MADDR_HI: if (bitCnt_q == 3'd7) state_d = ACK_MHI;
            ACK_MHI:  state_d = MADDR_LO;
            MADDR_LO: if (bitCnt_q == 3'd7) state_d = ACK_MLO;
            ACK_MLO:  state_d = WR_DATA;
            WR_DATA:  if (bitCnt_q == 3'd7) state_d = ACK_WR;
            ACK_WR:   state_d = WR_DATA;
            RD_DATA:  if (bitCnt_q == 3'd7) state_d = RD_ACK;
            RD_ACK:   state_d = sdaF ? WAIT_BUS : RD_DATA;
            default:  state_d = state_q;
         endcase
      end
   end

   // Datapath and outputs: sample on SCL rise, drive SDA on SCL fall
   always_comb begin
      bitCnt_d  = bitCnt_q;
      rxShift_d = rxShift_q;
      txShift_d = txShift_q;
      hiByte_d  = hiByte_q;
      rw_d      = rw_q;
      ptr_d     = ptr_q;
      sda_d     = sda_q;
      op_d      = op_q;
      wrStb_d   = 1'b0;
      wrAddr_d  = wrAddr_q;
      wrData_d  = wrData_q;
      rdReq_d   = 1'b0;
      rdAddr_d  = rdAddr_q;
      rdPipe_d  = RD_LAT'({rdPipe_q, rdReq_q});
      if (rdPipe_q[RD_LAT-1]) begin
         txShift_d = i2c_rdata;
      end
      if (startCond || stopCond) begin
         bitCnt_d = 3'd0;
         op_d     = 1'b0;
         sda_d    = 1'b1;
      end else if (sclRise) begin
         rxShift_d = rxNext;
         bitCnt_d  = bitCnt_q + 3'd1;
         case (state_q)
            DEV_ADDR: begin
               if (bitCnt_q == 3'd7) begin
                  rw_d = rxNext[0];
                  if (addrMatch) op_d = 1'b1;
               end
            end
            ACK_DEV: begin
               bitCnt_d = 3'd0;
               if (rw_q) begin
                  rdReq_d  = 1'b1;
                  rdAddr_d = ptr_q;
               end
            end
            MADDR_HI: if (bitCnt_q == 3'd7) hiByte_d = rxNext;
            MADDR_LO: if (bitCnt_q == 3'd7) ptr_d = ptrLoad;
            WR_DATA: begin
               if (bitCnt_q == 3'd7) begin
                  wrStb_d  = 1'b1;
                  wrAddr_d = ptr_q;
                  wrData_d = rxNext;
                  ptr_d    = ptrInc;
               end
            end
            RD_ACK: begin
               bitCnt_d = 3'd0;
               if (!sdaF) begin
                  ptr_d    = ptrInc;
                  rdReq_d  = 1'b1;
                  rdAddr_d = ptrInc;
               end else begin
                  op_d = 1'b0;
               end
            end
            ACK_MHI, ACK_MLO, ACK_WR: bitCnt_d = 3'd0;
            default: ;
         endcase
      end else if (sclFall) begin
         case (state_q)
            ACK_DEV, ACK_MHI, ACK_MLO, ACK_WR: sda_d = 1'b0;
            RD_DATA: begin
               sda_d     = txShift_q[7];
               txShift_d = {txShift_q[6:0], 1'b1};
            end
            default: sda_d = 1'b1;
         endcase
      end
   end

   // Datapath and output registers; reset releases SDA without waiting for a clock
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bitCnt_q  <= 3'd0;
         rxShift_q <= 8'h00;
         txShift_q <= 8'hFF;
         hiByte_q  <= 8'h00;
         rw_q      <= 1'b0;
         ptr_q     <= '0;
         rdPipe_q  <= '0;
         sda_q     <= 1'b1;
         op_q      <= 1'b0;
         wrStb_q   <= 1'b0;
         wrAddr_q  <= '0;
         wrData_q  <= 8'h00;
         rdReq_q   <= 1'b0;
         rdAddr_q  <= '0;
      end else begin
         bitCnt_q  <= bitCnt_d;
         rxShift_q <= rxShift_d;
         txShift_q <= txShift_d;
         hiByte_q  <= hiByte_d;
         rw_q      <= rw_d;
         ptr_q     <= ptr_d;
         rdPipe_q  <= rdPipe_d;
         sda_q     <= sda_d;
         op_q      <= op_d;
         wrStb_q   <= wrStb_d;
         wrAddr_q  <= wrAddr_d;
         wrData_q  <= wrData_d;
         rdReq_q   <= rdReq_d;
         rdAddr_q  <= rdAddr_d;
      end
   end

   assign i2c_sda_out   = sda_q;
   assign i2c_op        = op_q;
   assign i2c_xfc_write = wrStb_q;
   assign i2c_wraddr    = wrAddr_q;
   assign i2c_wdata     = wrData_q;
   assign i2c_rd_req    = rdReq_q;
   assign i2c_rdaddr    = rdAddr_q;

endmodule
